pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Hazard and redirect controller for the 5-stage CPU pipeline (IF/ID/EX/MEM/WB). Keeps a shadow pipeline of in-flight destination registers to detect read-after-write hazards against the instruction in ID. Drives stall, bubble and flush controls into the IF/ID, ID/EX and EX/MEM pipeline registers. Handles MEM-stage branch/jump redirects and keeps saturating stall and flush statistics counters.

## Interface
- CNT_W, 32, width of statistics counters
- WB_BYPASS, 0, 1 = register file is write-first, so the WB slot is excluded from hazard checks
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous reset, active-high
- id_valid_i  in  1  ID stage holds a real instruction
- id_rs1_i / id_rs2_i  in  5  ID source register indices
- id_use_rs1_i / id_use_rs2_i  in  1  instruction reads rs1 / rs2
- id_rd_i  in  5  ID destination register
- id_wen_i  in  1  instruction writes rd (R/I/load/JAL)
- id_load_i  in  1  instruction is a load (opcode 0000011)
- redirect_i  in  1  MEM stage has a taken branch or a JAL; PC takes the MEM target
- stall_o  out  1  hold PC and IF/ID
- bubble_idex_o  out  1  load a NOP into ID/EX
- flush_ifid_o  out  1  clear IF/ID
- flush_exmem_o  out  1  load a NOP into EX/MEM (kills the instruction now in EX)
- state_o  out  2  RUN=0, STALL=1, FLUSH=2
- stall_cnt_o  out  CNT_W  cycles with stall_o=1, saturating
- flush_cnt_o  out  CNT_W  redirects taken, saturating

## Operation
- Shadow slots EX, MEM, WB; each holds {valid, rd, load}. A slot with rd=0 is stored as invalid.
- Source match: the slot is valid, use_rsN=1, rsN!=0 and slot.rd==rsN.
- Hazard (default build): any source matches the EX slot, the MEM slot, or the WB slot (WB is checked only when WB_BYPASS=0). Hazard is gated by id_valid_i.
- Priority:
  - redirect_i=1: FLUSH action. stall_o=0, bubble_idex_o=1, flush_ifid_o=1, flush_exmem_o=1.
  - Otherwise, hazard: STALL action. stall_o=1, bubble_idex_o=1, flushes 0.
  - Otherwise: RUN action. All controls 0.
- Slot advance each posedge:
  - WB<=MEM always.
  - MEM<=EX, or an invalid slot on FLUSH.
  - EX<={id_valid_i&id_wen_i, id_rd_i, id_load_i} on RUN; an invalid slot on STALL or FLUSH.
- The redirecting instruction itself is in MEM and advances to WB, so a JAL rd write stays tracked.
- state_o registers the action taken in the previous cycle.
- Counters: stall_cnt increments on each STALL cycle; flush_cnt increments on each FLUSH cycle. Both hold at 2^CNT_W-1.

## Timing
- stall_o, bubble_idex_o and both flushes are combinational from the registered slots, ID inputs and redirect_i, all in the same cycle.
- Slots, state_o and counters update at posedge, with 1-cycle latency.
- Without forwarding, a dependent instruction directly behind its producer stalls 3 cycles (WB_BYPASS=0) or 2 cycles (WB_BYPASS=1).
- Redirect and hazard in the same cycle: FLUSH wins, stall_cnt is unchanged, flush_cnt increments by 1.
- Redirect during a multi-cycle stall: the stall ends immediately and the stalled ID instruction is flushed.
- While rst=1:
  - All control outputs are 0.
  - On the posedge, slots are cleared, state_o=RUN and counters=0.
- Reset mid-stall: stall_o is 0 from the cycle rst is asserted. On the first cycle after reset, ID is re-evaluated against empty slots.

## Configuration
- FORWARD_EN defined:
  - The datapath forwards EX/MEM and MEM/WB results.
  - Hazard is limited to the load-use case: a source matches the EX slot and EX.load=1. That gives a 1-cycle stall.
  - MEM and WB matches are ignored.
- FORWARD_EN undefined: full hazard check as described in Operation.

## Structure
- hazard_pkg:
  - State enum (RUN/STALL/FLUSH).
  - Slot struct {valid, rd[4:0], load}.
  - Opcode constants OP_LOAD=0000011 and OP_JAL=1101111.
- One sub-module, hazard_src_match: compares one slot against both ID sources and returns a match bit. It is instantiated per slot.
- Counters and slot registers live in the top.

## Test plan
- addi x1 then add x2,x1,x1 back-to-back (WB_BYPASS=0, no FORWARD_EN) -> stall_o high exactly 3 cycles, bubble_idex_o high on the same 3 cycles, stall_cnt_o=3.
- Same program with WB_BYPASS=1 -> stall 2 cycles. Producer with rd=x0 -> no stall.
- FORWARD_EN: lw x5 then add x6,x5,x0 -> 1 stall cycle. addi x5 then add x6,x5,x0 -> 0 stalls.
- Hazard pending plus redirect_i=1 in the same cycle -> stall_o=0, all three flush/bubble outputs 1, flush_cnt_o=1, stall_cnt_o unchanged; the next cycle the EX and MEM slots are invalid.
- rst asserted in the 2nd cycle of a 3-cycle stall -> stall_o=0 immediately; after release, state_o=RUN and counters=0.
- CNT_W=4 with a continuous hazard held for 20 cycles -> stall_cnt_o reaches 15 and stays at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
//
// Purpose : action/state encoding, shadow-slot record, opcode constants and a
//           slot constructor used by pipeline_hazard_ctrl and hazard_src_match.
// Ports   : none (package).
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       load;
    } slot_t;

    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam slot_t SLOT_EMPTY = '{valid: 1'b0, rd: 5'd0, load: 1'b0};

    // A write to x0 is architecturally discarded, so it never creates a hazard.
    function automatic slot_t make_slot(input logic wr, input logic [4:0] rd, input logic ld);
        slot_t s;
        s.valid = wr & (rd != 5'd0);
        s.rd    = rd;
        s.load  = ld;
        return s;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - ID-stage / redirect bundle and pipeline control outputs
//
// Purpose : groups the ID instruction descriptor, the MEM redirect request and
//           the stall/bubble/flush controls between the pipeline and the controller.
// Signals : id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, id_rd_i,
//           id_wen_i, id_load_i, redirect_i      (pipeline -> controller)
//           stall_o, bubble_idex_o, flush_ifid_o, flush_exmem_o (controller -> pipeline)
// Modports: master = pipeline side, slave = hazard controller side.
interface pipeline_hazard_ctrl_if;

    logic       id_valid_i;
    logic [4:0] id_rs1_i;
    logic [4:0] id_rs2_i;
    logic       id_use_rs1_i;
    logic       id_use_rs2_i;
    logic [4:0] id_rd_i;
    logic       id_wen_i;
    logic       id_load_i;
    logic       redirect_i;

    logic       stall_o;
    logic       bubble_idex_o;
    logic       flush_ifid_o;
    logic       flush_exmem_o;

    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
               id_rd_i, id_wen_i, id_load_i, redirect_i,
        input  stall_o, bubble_idex_o, flush_ifid_o, flush_exmem_o
    );

    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
               id_rd_i, id_wen_i, id_load_i, redirect_i,
        output stall_o, bubble_idex_o, flush_ifid_o, flush_exmem_o
    );

endinterface

// File: rtl/hazard_src_match.sv
// rtl/hazard_src_match.sv - compares one shadow slot against both ID source registers
//
// Purpose : raises match_o when the slot holds a live write to a register that
//           the ID instruction actually reads (x0 reads never match).
// Ports   : slot_i       shadow slot {valid, rd, load}
//           rs1_i/rs2_i  ID source indices, use_rs1_i/use_rs2_i their read enables
//           load_only_i  1 = only a producing load counts (load-use detection)
//           match_o      combinational match result
module hazard_src_match
    import hazard_pkg::*;
(
    input  slot_t      slot_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic       use_rs1_i,
    input  logic       use_rs2_i,
    input  logic       load_only_i,
    output logic       match_o
);

    logic hit_rs1;
    logic hit_rs2;

    assign hit_rs1 = use_rs1_i && (rs1_i != 5'd0) && (slot_i.rd == rs1_i);
    assign hit_rs2 = use_rs2_i && (rs2_i != 5'd0) && (slot_i.rd == rs2_i);

    assign match_o = slot_i.valid && (hit_rs1 || hit_rs2) && (!load_only_i || slot_i.load);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - RAW hazard detection, MEM redirect flushing and statistics
//
// Purpose : tracks in-flight destination registers in EX/MEM/WB shadow slots,
//           stalls the front end on read-after-write hazards, flushes on MEM
//           redirects and counts stall cycles and redirects (saturating).
// Ports   : clk, rst (synchronous, active-high)
//           hz          pipeline_hazard_ctrl_if.slave (ID descriptor, redirect, controls)
//           state_o     action taken last cycle: RUN=0, STALL=1, FLUSH=2
//           stall_cnt_o stall cycles, flush_cnt_o redirects taken
// Params  : CNT_W counter width; WB_BYPASS=1 drops the WB slot from the check.
// Macro   : FORWARD_EN - datapath forwards, only load-use against EX stalls.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int WB_BYPASS = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  hz,
    output logic [1:0]             state_o,
    output logic [CNT_W-1:0]       stall_cnt_o,
    output logic [CNT_W-1:0]       flush_cnt_o
);

`ifdef FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // With forwarding, MEM/WB results reach EX in time; only a load in EX is too late.
    localparam bit EX_LOAD_ONLY = FWD;
    localparam bit EN_MEM       = !FWD;
    localparam bit EN_WB        = !FWD && (WB_BYPASS == 0);

    slot_t            ex_q,  ex_d;
    slot_t            mem_q, mem_d;
    slot_t            wb_q,  wb_d;
    state_e           state_q;
    state_e           act;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic m_ex;
    logic m_mem;
    logic m_wb;
    logic hazard;

    hazard_src_match u_match_ex (
        .slot_i      (ex_q),
        .rs1_i       (hz.id_rs1_i),
        .rs2_i       (hz.id_rs2_i),
        .use_rs1_i   (hz.id_use_rs1_i),
        .use_rs2_i   (hz.id_use_rs2_i),
        .load_only_i (EX_LOAD_ONLY),
        .match_o     (m_ex)
    );

    hazard_src_match u_match_mem (
        .slot_i      (mem_q),
        .rs1_i       (hz.id_rs1_i),
        .rs2_i       (hz.id_rs2_i),
        .use_rs1_i   (hz.id_use_rs1_i),
        .use_rs2_i   (hz.id_use_rs2_i),
        .load_only_i (1'b0),
        .match_o     (m_mem)
    );

    hazard_src_match u_match_wb (
        .slot_i      (wb_q),
        .rs1_i       (hz.id_rs1_i),
        .rs2_i       (hz.id_rs2_i),
        .use_rs1_i   (hz.id_use_rs1_i),
        .use_rs2_i   (hz.id_use_rs2_i),
        .load_only_i (1'b0),
        .match_o     (m_wb)
    );

    always_comb begin
        hazard = hz.id_valid_i && (m_ex || (EN_MEM && m_mem) || (EN_WB && m_wb));

        // A redirect kills the stalled ID instruction anyway, so it overrides the stall.
        act = ST_RUN;
        if (rst) begin
            act = ST_RUN;
        end else if (hz.redirect_i) begin
            act = ST_FLUSH;
        end else if (hazard) begin
            act = ST_STALL;
        end

        hz.stall_o       = (act == ST_STALL);
        hz.bubble_idex_o = (act != ST_RUN);
        hz.flush_ifid_o  = (act == ST_FLUSH);
        hz.flush_exmem_o = (act == ST_FLUSH);

        // The redirecting instruction sits in MEM and still retires through WB.
        wb_d  = mem_q;
        mem_d = (act == ST_FLUSH) ? SLOT_EMPTY : ex_q;
        ex_d  = (act == ST_RUN)
              ? make_slot(hz.id_valid_i & hz.id_wen_i, hz.id_rd_i, hz.id_load_i)
              : SLOT_EMPTY;

        stall_cnt_d = stall_cnt_q;
        if ((act == ST_STALL) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        flush_cnt_d = flush_cnt_q;
        if ((act == ST_FLUSH) && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= SLOT_EMPTY;
            mem_q       <= SLOT_EMPTY;
            wb_q        <= SLOT_EMPTY;
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            state_q     <= act;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign state_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule
